// File: rtl/npu_seq_scheduler_if.sv
// npu_seq_scheduler_if: instruction handshake and PE-row control bundle between NPU controller and scheduler.
interface npu_seq_scheduler_if #(
    parameter int N         = 10,
    parameter int MUX_WIDTH = 4,
    parameter int LEN_W     = 5
);
    localparam int W_IN = 3 + MUX_WIDTH + LEN_W;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [W_IN-1:0]      instr;
    logic                 flush;
    logic                 err_clr;
    logic [N-1:0]         pe_en;
    logic [N-1:0]         pe_mode_sel;
    logic [N-1:0]         pe_reg_reset;
    logic [MUX_WIDTH-1:0] pe_mux_sel;
    logic                 out_valid;
    logic                 busy;
    logic                 done;
    logic                 err;
    modport master (
        output instr_valid, instr, flush, err_clr,
        input  instr_ready, pe_en, pe_mode_sel, pe_reg_reset, pe_mux_sel, out_valid, busy, done, err
    );
    modport slave (
        input  instr_valid, instr, flush, err_clr,
        output instr_ready, pe_en, pe_mode_sel, pe_reg_reset, pe_mux_sel, out_valid, busy, done, err
    );
endinterface

// File: rtl/npu_seq_scheduler.sv
// npu_seq_scheduler: runs packed PE-row instructions for LEN+1 cycles, driving PE enable/mode/reset masks and read-out select.
module npu_seq_scheduler #(
    parameter int N         = 10,
    parameter int MUX_WIDTH = 4,
    parameter int LEN_W     = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    npu_seq_scheduler_if.slave  bus
);
    localparam int W_IN = 3 + MUX_WIDTH + LEN_W;
    typedef enum logic {IDLE, EXEC} state_t;
    state_t               state, state_nx;
    logic [LEN_W-1:0]     cnt;
    logic [MUX_WIDTH-1:0] ptr;
    logic [N-1:0]         en_q, mode_q, rst_q, mac_mask;
    logic                 rd_q, live, err_q, exec, accept, legal;
    logic [2:0]           op;
    logic [MUX_WIDTH-1:0] arg;
    logic [LEN_W-1:0]     len;
    assign op     = bus.instr[W_IN-1 -: 3];
    assign arg    = bus.instr[LEN_W +: MUX_WIDTH];
    assign len    = bus.instr[LEN_W-1:0];
    assign exec   = state == EXEC;
    assign legal  = op < 3'd4 || (op == 3'd4 && int'(arg) < N);
    assign accept = bus.instr_valid && bus.instr_ready;
    // live holds instr_ready low until the first clock after reset release
    assign bus.instr_ready = live && (!exec || (cnt == '0 && !bus.flush));
    always_comb begin
        mac_mask = '0;
        for (int i = 0; i < N; i++) mac_mask[i] = int'(arg) >= i;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = accept ? (legal ? EXEC : IDLE) : (exec && (bus.flush || cnt == '0)) ? IDLE : state;
    end
    always_comb begin
        bus.busy         = exec;
        bus.done         = exec && cnt == '0 && !bus.flush;
        bus.pe_en        = exec ? en_q : '0;
        bus.pe_mode_sel  = exec ? mode_q : '0;
        bus.pe_reg_reset = exec ? rst_q : '0;
        bus.out_valid    = exec && rd_q;
        bus.pe_mux_sel   = (exec && rd_q) ? ptr : '0;
        bus.err          = err_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live   <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= '0;
            ptr    <= '0;
            en_q   <= '0;
            mode_q <= '0;
            rst_q  <= '0;
            rd_q   <= 1'b0;
        end else begin
            live  <= 1'b1;
            err_q <= (accept && !legal) || (err_q && !bus.err_clr);
            cnt   <= accept ? len : (exec && cnt != '0 && !bus.flush) ? cnt - 1'b1 : '0;
            if (accept && op == 3'd4) ptr <= arg;
            else if (exec && rd_q)    ptr <= (int'(ptr) == N - 1) ? '0 : ptr + 1'b1;
            if (accept) begin
                en_q   <= (op == 3'd2 || op == 3'd3) ? mac_mask : '0;
                mode_q <= (op == 3'd3) ? mac_mask : '0;
                rst_q  <= (op == 3'd1) ? '1 : '0;
                rd_q   <= op == 3'd4;
            end
        end
    end
endmodule

// File: tb/tb_npu_seq_scheduler.sv
// tb_npu_seq_scheduler: directed and random stimulus against a frame-queue reference model of the scheduler.
module tb_npu_seq_scheduler;
    localparam int N = 10, MW = 4, LW = 5, W_IN = 3 + MW + LW;
    typedef struct packed {
        logic [N-1:0]  en;
        logic [N-1:0]  mode;
        logic [N-1:0]  rst;
        logic [MW-1:0] mux;
        logic          ov;
        logic          done;
    } frame_t;
    logic clk = 1'b0, rst_n = 1'b0;
    int checks = 0, errors = 0;
    frame_t q[$];
    logic err_m = 1'b0, started = 1'b0;
    npu_seq_scheduler_if #(.N(N), .MUX_WIDTH(MW), .LEN_W(LW)) bus ();
    npu_seq_scheduler #(.N(N), .MUX_WIDTH(MW), .LEN_W(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [W_IN-1:0] mk(input int op, input int arg, input int len);
        logic [2:0] o = 3'(op);
        logic [MW-1:0] a = MW'(arg);
        logic [LW-1:0] l = LW'(len);
        return {o, a, l};
    endfunction
    // every instruction expands into LEN+1 expected output frames
    task automatic push_instr(input int op, input int arg, input int len);
        frame_t f;
        int k = (arg + 1 < N) ? arg + 1 : N;
        logic [N-1:0] mask = N'((1 << k) - 1);
        for (int j = 0; j <= len; j++) begin
            f.en   = (op == 2 || op == 3) ? mask : '0;
            f.mode = (op == 3) ? mask : '0;
            f.rst  = (op == 1) ? '1 : '0;
            f.ov   = op == 4;
            f.mux  = (op == 4) ? MW'((arg + j) % N) : '0;
            f.done = j == len;
            q.push_back(f);
        end
    endtask
    task automatic cyc(input logic v, input logic [W_IN-1:0] ins, input logic fl, input logic ec);
        frame_t f;
        logic rdy;
        int op, arg, len;
        @(negedge clk);
        bus.instr_valid = v;
        bus.instr = ins;
        bus.flush = fl;
        bus.err_clr = ec;
        #1;
        f = (q.size() != 0) ? q[0] : '0;
        rdy = started && (q.size() == 0 || (q.size() == 1 && !fl));
        chk("ready", bus.instr_ready, rdy);
        chk("busy", bus.busy, q.size() != 0);
        chk("pe_en", bus.pe_en, f.en);
        chk("mode", bus.pe_mode_sel, f.mode);
        chk("regrst", bus.pe_reg_reset, f.rst);
        chk("mux", bus.pe_mux_sel, f.mux);
        chk("out_valid", bus.out_valid, f.ov);
        chk("done", bus.done, f.done && !fl);
        chk("err", bus.err, err_m);
        @(posedge clk);
        op  = int'(ins[W_IN-1 -: 3]);
        arg = int'(ins[LW +: MW]);
        len = int'(ins[LW-1:0]);
        if (fl) q.delete();
        else if (q.size() != 0) void'(q.pop_front());
        if (v && rdy && (op < 4 || (op == 4 && arg < N))) push_instr(op, arg, len);
        err_m = (v && rdy && !(op < 4 || (op == 4 && arg < N))) ? 1'b1 : ec ? 1'b0 : err_m;
        started = 1'b1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    endtask
    initial begin
        logic [MW-1:0] rd_exp [5];
        rd_exp = '{4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.flush = 1'b0;
        bus.err_clr = 1'b0;
        #12;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_en", bus.pe_en, '0);
        chk("rst_err", bus.err, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        started = 1'b1;
        // T2 MAC ARG=3 LEN=4
        cyc(1'b1, mk(2, 3, 4), 1'b0, 1'b0);
        #1 chk("t2_en", bus.pe_en, 10'h00F);
        idle(6);
        // T3 back-to-back CLEAR then MAC_RELU
        cyc(1'b1, mk(1, 0, 0), 1'b0, 1'b0);
        #1 chk("t3_clr", bus.pe_reg_reset, 10'h3FF);
        cyc(1'b1, mk(3, 15, 1), 1'b0, 1'b0);
        #1 chk("t3_relu", bus.pe_mode_sel, 10'h3FF);
        idle(3);
        // T4 READ walk with wrap
        cyc(1'b1, mk(4, 8, 4), 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            #1 chk("t4_mux", bus.pe_mux_sel, rd_exp[j]);
            cyc(1'b0, '0, 1'b0, 1'b0);
        end
        idle(1);
        // T5 illegal opcode, clear, out-of-range READ
        cyc(1'b1, mk(6, 0, 0), 1'b0, 1'b0);
        #1 chk("t5_err", bus.err, 1'b1);
        chk("t5_busy", bus.busy, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        #1 chk("t5_clr", bus.err, 1'b0);
        cyc(1'b1, mk(4, 12, 0), 1'b0, 1'b0);
        #1 chk("t5_rd12", bus.err, 1'b1);
        cyc(1'b1, mk(7, 0, 0), 1'b0, 1'b1);
        idle(1);
        // T6 flush in 2nd cycle
        cyc(1'b1, mk(2, 5, 7), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        #1 chk("t6_busy", bus.busy, 1'b0);
        chk("t6_en", bus.pe_en, '0);
        idle(2);
        // T1 async reset mid-MAC
        cyc(1'b1, mk(2, 9, 7), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.flush = 1'b0;
        bus.err_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("t1_busy", bus.busy, 1'b0);
        chk("t1_en", bus.pe_en, '0);
        chk("t1_err", bus.err, 1'b0);
        chk("t1_done", bus.done, 1'b0);
        q.delete();
        err_m = 1'b0;
        started = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        started = 1'b1;
        idle(1);
        for (int i = 0; i < 2000; i++) begin
            int op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
            cyc($urandom_range(0, 9) < 6, mk(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 5))),
                $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
        end
        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
